// File: rtl/exmem_stage.sv
// EX/MEM pipeline register with the data memory behind it. A memory access
// takes MEM_WAIT wait cycles (Stall high, bubble downstream) plus a final cycle.
module exmem_stage #(
    parameter int DEPTH    = 256,
    parameter int ADDR_W   = 8,
    parameter int MEM_WAIT = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] InstructionIn,
    input  logic [31:0] ALUResultIn,
    input  logic [15:0] StoreDataIn,
    input  logic [31:0] OpsIn,
    output logic [15:0] InstructionOut,
    output logic [31:0] ALUResultOut,
    output logic [15:0] ReadDataOut,
    output logic [31:0] OpsOut,
    output logic [31:0] ExForward,
    output logic        LoadPending,
    output logic        Stall
);
    localparam logic [3:0] OP_LBU = 4'b0100;
    localparam logic [3:0] OP_SB  = 4'b0101;
    localparam logic [3:0] OP_LW  = 4'b0110;
    localparam logic [3:0] OP_SW  = 4'b0111;
    localparam bit         HAS_WAIT = (MEM_WAIT != 0);
    localparam logic [2:0] LAST_CNT = HAS_WAIT ? 3'(MEM_WAIT - 1) : 3'd0;

    typedef enum logic {S_READY, S_WAIT} state_t;

    function automatic logic is_load(input logic [3:0] op);
        return (op == OP_LW) || (op == OP_LBU);
    endfunction

    function automatic logic is_store(input logic [3:0] op);
        return (op == OP_SW) || (op == OP_SB);
    endfunction

    state_t      state, state_nxt;
    logic [2:0]  cnt, cnt_nxt;
    logic [15:0] instr_r, sd_r;
    logic [31:0] alu_r, ops_r;
    logic        latch;

    logic [15:0]       mem [DEPTH];
    logic [ADDR_W-1:0] idx;
    logic              bsel;
    logic [15:0]       rd, wdata;
    logic              we;

    assign latch = (state == S_READY);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            S_READY: begin
                if (HAS_WAIT && (is_load(InstructionIn[15:12]) || is_store(InstructionIn[15:12]))) begin
                    state_nxt = S_WAIT;
                    cnt_nxt   = 3'd0;
                end
            end
            S_WAIT: begin
                if (cnt == LAST_CNT) begin
                    state_nxt = S_READY;
                    cnt_nxt   = 3'd0;
                end else begin
                    cnt_nxt = cnt + 3'd1;
                end
            end
            default: begin
                state_nxt = S_READY;
                cnt_nxt   = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_READY;
            cnt     <= 3'd0;
            instr_r <= 16'h0000;
            alu_r   <= 32'h0;
            sd_r    <= 16'h0000;
            ops_r   <= 32'h0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (latch) begin
                instr_r <= InstructionIn;
                alu_r   <= ALUResultIn;
                sd_r    <= StoreDataIn;
                ops_r   <= OpsIn;
            end
        end
    end

    // The registered op is in its final (READY) cycle, so a store commits at this edge.
    assign idx  = alu_r[ADDR_W:1];
    assign bsel = alu_r[0];
    assign rd   = mem[idx];
    assign we   = latch && is_store(instr_r[15:12]) && !rst;

    always_comb begin
        wdata = sd_r;
        if (instr_r[15:12] == OP_SB)
            wdata = bsel ? {sd_r[7:0], rd[7:0]} : {rd[15:8], sd_r[7:0]};
    end

    always_ff @(posedge clk) begin
        if (we)
            mem[idx] <= wdata;
    end

    assign Stall          = (state == S_WAIT);
    assign InstructionOut = Stall ? 16'h0000 : instr_r;
    assign LoadPending    = !Stall && is_load(instr_r[15:12]);
    assign ALUResultOut   = alu_r;
    assign ExForward      = alu_r;
    assign OpsOut         = ops_r;
    assign ReadDataOut    = (instr_r[15:12] == OP_LBU) ? {8'h00, (bsel ? rd[15:8] : rd[7:0])} : rd;
endmodule

// File: tb/tb_exmem_stage.sv
// Directed bench for exmem_stage: three instances (MEM_WAIT 0, 2, 3) share one
// input bundle; each scenario checks only the instance it targets.
module tb_exmem_stage;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] ins = 16'h0;
    logic [31:0] alu = 32'h0;
    logic [15:0] sd  = 16'h0;
    logic [31:0] ops = 32'h0;

    logic [15:0] i0, i2, i3, r0, r2, r3;
    logic [31:0] a0, a2, a3, o0, o2, o3, f0, f2, f3;
    logic        l0, l2, l3, s0, s2, s3;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    exmem_stage #(.DEPTH(256), .ADDR_W(8), .MEM_WAIT(0)) u0 (
        .clk(clk), .rst(rst), .InstructionIn(ins), .ALUResultIn(alu), .StoreDataIn(sd), .OpsIn(ops),
        .InstructionOut(i0), .ALUResultOut(a0), .ReadDataOut(r0), .OpsOut(o0), .ExForward(f0),
        .LoadPending(l0), .Stall(s0));
    exmem_stage #(.DEPTH(256), .ADDR_W(8), .MEM_WAIT(2)) u2 (
        .clk(clk), .rst(rst), .InstructionIn(ins), .ALUResultIn(alu), .StoreDataIn(sd), .OpsIn(ops),
        .InstructionOut(i2), .ALUResultOut(a2), .ReadDataOut(r2), .OpsOut(o2), .ExForward(f2),
        .LoadPending(l2), .Stall(s2));
    exmem_stage #(.DEPTH(256), .ADDR_W(8), .MEM_WAIT(3)) u3 (
        .clk(clk), .rst(rst), .InstructionIn(ins), .ALUResultIn(alu), .StoreDataIn(sd), .OpsIn(ops),
        .InstructionOut(i3), .ALUResultOut(a3), .ReadDataOut(r3), .OpsOut(o3), .ExForward(f3),
        .LoadPending(l3), .Stall(s3));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Present one EX-stage bundle, clock it in, settle just after the edge.
    task automatic step(input logic [15:0] in_i, input logic [31:0] in_a, input logic [15:0] in_d);
        ins = in_i;
        alu = in_a;
        sd  = in_d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_instr", 32'(i0), 32'h0);
        check("rst_alu",   a0, 32'h0);
        check("rst_ops",   o0, 32'h0);
        check("rst_fwd",   f3, 32'h0);
        check("rst_ldp",   32'(l3), 32'h0);
        check("rst_stall", 32'(s3), 32'h0);
        rst = 1'b0;

        // Non-memory op through MEM_WAIT=2: one-cycle latency, no stall
        ops = 32'hA5A5_0F0F;
        step(16'h1000, 32'h1234_5678, 16'h0);
        check("add_alu",   a2, 32'h1234_5678);
        check("add_fwd",   f2, 32'h1234_5678);
        check("add_ops",   o2, 32'hA5A5_0F0F);
        check("add_instr", 32'(i2), 32'h1000);
        check("add_ldp",   32'(l2), 32'h0);
        check("add_stall", 32'(s2), 32'h0);
        ops = 32'h0;

        // MEM_WAIT=0: SW then LW to 0x10
        step(16'h7000, 32'h10, 16'hBEEF);
        check("sw_instr", 32'(i0), 32'h7000);
        check("sw_stall", 32'(s0), 32'h0);
        step(16'h6000, 32'h10, 16'h0);
        check("lw_data",  32'(r0), 32'hBEEF);
        check("lw_ldp",   32'(l0), 32'h1);
        check("lw_stall", 32'(s0), 32'h0);

        // SB over 0x1234 at word 0x10 (bytes 0x20/0x21)
        step(16'h7000, 32'h20, 16'h1234);
        step(16'h5000, 32'h21, 16'h55AA);
        check("sb_stall", 32'(s0), 32'h0);
        step(16'h4000, 32'h20, 16'h0);
        check("lbu_lo", 32'(r0), 32'h0034);
        step(16'h4000, 32'h21, 16'h0);
        check("lbu_hi", 32'(r0), 32'h00AA);
        check("lbu_ldp", 32'(l0), 32'h1);
        step(16'h6000, 32'h20, 16'h0);
        check("sb_word", 32'(r0), 32'hAA34);

        // Address wrap: 0x3FE aliases 0x1FE (word 0xFF); high ALU bits ignored
        step(16'h7000, 32'hF000_03FE, 16'hCAFE);
        step(16'h6000, 32'h0000_01FE, 16'h0);
        check("wrap", 32'(r0), 32'hCAFE);

        // Drain the waiting instances before the MEM_WAIT=3 scenarios
        for (int k = 0; k < 8; k++) step(16'h0000, 32'h0, 16'h0);
        check("drain_stall", 32'(s3), 32'h0);

        // MEM_WAIT=3: SW 0x1111 to 0x08, next instruction LW 0x08 held upstream
        step(16'h7000, 32'h08, 16'h1111);
        ins = 16'h6000; alu = 32'h08; sd = 16'h0;
        for (int k = 0; k < 3; k++) begin
            check("sw3_stall", 32'(s3), 32'h1);
            check("sw3_bubble", 32'(i3), 32'h0);
            check("sw3_hold", a3, 32'h08);
            @(posedge clk);
            #1;
        end
        check("sw3_final_stall", 32'(s3), 32'h0);
        check("sw3_final_instr", 32'(i3), 32'h7000);
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            check("lw3_stall", 32'(s3), 32'h1);
            check("lw3_ldp_gated", 32'(l3), 32'h0);
            @(posedge clk);
            #1;
        end
        check("lw3_stall_end", 32'(s3), 32'h0);
        check("lw3_instr", 32'(i3), 32'h6000);
        check("lw3_ldp", 32'(l3), 32'h1);
        check("lw3_data", 32'(r3), 32'h1111);

        // MEM_WAIT=3: SW 0x5555 to 0x08, reset during the second wait cycle
        step(16'h7000, 32'h08, 16'h5555);
        ins = 16'h0000; alu = 32'h0; sd = 16'h0;
        @(posedge clk);
        #1;
        check("abort_pre_stall", 32'(s3), 32'h1);
        rst = 1'b1;
        #2;
        check("abort_stall", 32'(s3), 32'h0);
        check("abort_instr", 32'(i3), 32'h0);
        check("abort_alu",   a3, 32'h0);
        check("abort_ldp",   32'(l3), 32'h0);
        rst = 1'b0;
        step(16'h6000, 32'h08, 16'h0);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
        end
        check("abort_instr_ld", 32'(i3), 32'h6000);
        check("abort_old_data", 32'(r3), 32'h1111);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
